bpu_update_scheduler: RTL and testbench
=======================================

// Module: bpu_update_scheduler
// PURPOSE
//  Arbitrates and buffers branch-predictor training updates from two sources into the predictor's
//  single update port (update_i/update_pc_i/actual_taken_i/actual_target_i/is_branch_i).
//  - Source EX: conditional branches resolved in execute.
//  - Source JMP: JAL/JALR resolved in decode/execute.
//  Sits between the pipeline resolution logic and branch_predictor; delivers at most one update per cycle.
// PARAMETERS
//  QUEUE_DEPTH   4   FIFO entries; power of 2, >=2
//  ADDR_WIDTH    32  PC/target width; matches addr_t
// PORTS
//  clk_i               in   1    clock
//  rst_ni              in   1    reset, asynchronous, active-low
//  ex_valid_i          in   1    EX update offered
//  ex_ready_o          out  1    EX update accepted when valid&ready
//  ex_pc_i             in   AW   PC of resolved branch
//  ex_taken_i          in   1    actual outcome
//  ex_target_i         in   AW   actual target
//  jmp_valid_i         in   1    JMP update offered (always taken)
//  jmp_ready_o         out  1    JMP update accepted when valid&ready
//  jmp_pc_i            in   AW   PC of jump
//  jmp_target_i        in   AW   jump target
//  flush_i             in   1    discard all queued and incoming updates
//  enable_i            in   1    1=drain queue to predictor; 0=hold (still accepts)
//  bpu_update_o        out  1    to predictor update_i
//  bpu_update_pc_o     out  AW   to update_pc_i
//  bpu_taken_o         out  1    to actual_taken_i
//  bpu_target_o        out  AW   to actual_target_i
//  bpu_is_branch_o     out  1    to is_branch_i
//  queue_count_o       out  $clog2(QUEUE_DEPTH)+1  current occupancy
//  update_cnt_o        out  32   total updates delivered, saturating
// BEHAVIOUR
//  - Storage: circular FIFO, wr_ptr/rd_ptr of $clog2(QUEUE_DEPTH) bits, wrap modulo QUEUE_DEPTH.
//    Occupancy counter ranges 0..QUEUE_DEPTH.
//  - Reset: ptrs=0, count=0, update_cnt_o=0. All bpu_* outputs = 0 (bus outputs driven 0 when empty).
//    ex_ready_o=1; jmp_ready_o=1 (QUEUE_DEPTH>=2). Asserting reset mid-operation drops all entries.
//  - free = QUEUE_DEPTH - count, using the registered count only. A same-cycle dequeue is not credited.
//  - ex_ready_o  = !flush_i && free>=1.
//  - jmp_ready_o = !flush_i && (free>=2 || (free==1 && !ex_valid_i)).
//    EX has priority; the valid->ready combinational path is permitted.
//  - Both accepted in one cycle: EX written at wr_ptr, JMP at wr_ptr+1; wr_ptr advances by 2.
//  - Entry fields: {pc, taken, target, is_branch}.
//    EX entries: is_branch=1, taken=ex_taken_i. JMP entries: is_branch=1, taken=1.
//  - Drain: bpu_update_o = enable_i && !flush_i && count!=0. Outputs are driven combinationally from the head entry.
//    The predictor always accepts, so the head pops at each edge where bpu_update_o=1.
//  - Latency: an entry accepted at edge N appears on bpu_* in cycle N+1 if the queue was empty and enable_i=1.
//  - Simultaneous push and pop: count += pushes - pop. Full queue with a pop still gives ex_ready_o=0 that cycle.
//  - flush_i: no push, no pop. At the next edge ptrs=0 and count=0; the readies reassert in the following cycle.
//  - enable_i=0: queue holds and fills to full. Back-pressure only; no entry is ever lost except by flush or reset.
//  - update_cnt_o increments on every edge with bpu_update_o=1 and saturates at 32'hFFFF_FFFF.
//    flush_i does not clear it.
//  - bpu_* bus outputs are 0 whenever count==0, independent of stale FIFO contents.
// TESTING
//  1. Reset, EX pc=0x100 taken tgt=0x200, enable=1
//     -> next cycle bpu_update_o=1, pc=0x100, taken=1, tgt=0x200; update_cnt_o=1.
//  2. EX(0x10) and JMP(0x20) valid in the same cycle, queue empty
//     -> both accepted; bpu delivers 0x10 then 0x20 on consecutive cycles.
//  3. enable=0, offer 5 EX updates (DEPTH=4)
//     -> 4 accepted, ex_ready_o=0 on the 5th, count=4.
//     Then enable=1 -> 4 updates drain in FIFO order; ready reasserts one cycle after the first pop.
//  4. count=3 (DEPTH=4), EX and JMP both valid
//     -> EX accepted, jmp_ready_o=0; JMP accepted next cycle once a slot frees.
//  5. Queue holds 3 entries, flush_i=1 with EX valid
//     -> ex_ready_o=0, bpu_update_o=0; next cycle count=0, no stale update emitted.
//  6. Run wr_ptr through 3 full wraps with interleaved push/pop -> order preserved, count never exceeds 4.

Source files
------------

// File: rtl/bpu_update_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bpu_update_scheduler: merges EX and JMP training updates into a FIFO that   |
// | drains into the branch predictor's single update port.                      |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module bpu_update_scheduler #(
  parameter int QUEUE_DEPTH = 4,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           ex_valid_i,
  output logic                           ex_ready_o,
  input  logic [ADDR_WIDTH-1:0]          ex_pc_i,
  input  logic                           ex_taken_i,
  input  logic [ADDR_WIDTH-1:0]          ex_target_i,
  input  logic                           jmp_valid_i,
  output logic                           jmp_ready_o,
  input  logic [ADDR_WIDTH-1:0]          jmp_pc_i,
  input  logic [ADDR_WIDTH-1:0]          jmp_target_i,
  input  logic                           flush_i,
  input  logic                           enable_i,
  output logic                           bpu_update_o,
  output logic [ADDR_WIDTH-1:0]          bpu_update_pc_o,
  output logic                           bpu_taken_o,
  output logic [ADDR_WIDTH-1:0]          bpu_target_o,
  output logic                           bpu_is_branch_o,
  output logic [$clog2(QUEUE_DEPTH):0]   queue_count_o,
  output logic [31:0]                    update_cnt_o
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(QUEUE_DEPTH);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic                  taken;
    logic [ADDR_WIDTH-1:0] target;
    logic                  is_branch;
  } entry_t;

  entry_t        mem_q [QUEUE_DEPTH];
  entry_t        mem_d [QUEUE_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   update_cnt_q, update_cnt_d;

  logic [CW-1:0] free;
  logic [PW-1:0] jmp_idx;
  logic          ex_push, jmp_push, pop;
  entry_t        head;

  always_comb begin
    // Free space uses only the registered count; a same-cycle pop is not credited.
    free        = C_DEPTH - count_q;
    ex_ready_o  = !flush_i && (free != '0);
    jmp_ready_o = !flush_i && ((free >= CW'(2)) || ((free == CW'(1)) && !ex_valid_i));
    ex_push     = ex_valid_i && ex_ready_o;
    jmp_push    = jmp_valid_i && jmp_ready_o;
    pop         = enable_i && !flush_i && (count_q != '0);

    mem_d   = mem_q;
    jmp_idx = ex_push ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
    if (ex_push) begin
      mem_d[wr_ptr_q] = '{pc: ex_pc_i, taken: ex_taken_i, target: ex_target_i, is_branch: 1'b1};
    end
    if (jmp_push) begin
      mem_d[jmp_idx] = '{pc: jmp_pc_i, taken: 1'b1, target: jmp_target_i, is_branch: 1'b1};
    end

    wr_ptr_d = wr_ptr_q + PW'(ex_push) + PW'(jmp_push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(ex_push) + CW'(jmp_push) - CW'(pop);
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end

    update_cnt_d = update_cnt_q;
    if (pop && (update_cnt_q != 32'hFFFF_FFFF)) begin
      update_cnt_d = update_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      update_cnt_q <= '0;
    end else begin
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      update_cnt_q <= update_cnt_d;
    end
  end

  // Bus is forced to zero when empty so stale entries never leak out.
  assign head            = (count_q == '0) ? '0 : mem_q[rd_ptr_q];
  assign bpu_update_o    = pop;
  assign bpu_update_pc_o = head.pc;
  assign bpu_taken_o     = head.taken;
  assign bpu_target_o    = head.target;
  assign bpu_is_branch_o = head.is_branch;
  assign queue_count_o   = count_q;
  assign update_cnt_o    = update_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_bpu_update_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_bpu_update_scheduler: scoreboard bench for bpu_update_scheduler.         |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_bpu_update_scheduler;

  localparam int DEPTH = 4;
  localparam int AW    = 32;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          ex_valid = 1'b0, ex_taken = 1'b0, jmp_valid = 1'b0;
  logic [AW-1:0] ex_pc = '0, ex_target = '0, jmp_pc = '0, jmp_target = '0;
  logic          flush = 1'b0, enable = 1'b0;
  logic          ex_ready_o, jmp_ready_o, bpu_update_o, bpu_taken_o, bpu_is_branch_o;
  logic [AW-1:0] bpu_update_pc_o, bpu_target_o;
  logic [$clog2(DEPTH):0] queue_count_o;
  logic [31:0]   update_cnt_o;

  bpu_update_scheduler #(.QUEUE_DEPTH(DEPTH), .ADDR_WIDTH(AW)) u_dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .ex_valid_i      (ex_valid),
    .ex_ready_o      (ex_ready_o),
    .ex_pc_i         (ex_pc),
    .ex_taken_i      (ex_taken),
    .ex_target_i     (ex_target),
    .jmp_valid_i     (jmp_valid),
    .jmp_ready_o     (jmp_ready_o),
    .jmp_pc_i        (jmp_pc),
    .jmp_target_i    (jmp_target),
    .flush_i         (flush),
    .enable_i        (enable),
    .bpu_update_o    (bpu_update_o),
    .bpu_update_pc_o (bpu_update_pc_o),
    .bpu_taken_o     (bpu_taken_o),
    .bpu_target_o    (bpu_target_o),
    .bpu_is_branch_o (bpu_is_branch_o),
    .queue_count_o   (queue_count_o),
    .update_cnt_o    (update_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [AW-1:0] pc;
    logic          taken;
    logic [AW-1:0] target;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   exp_cnt  = 0;
  int   max_seen = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // Reference model: the scoreboard depth is the expected occupancy.
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      sb.delete();
      exp_cnt = 0;
    end else begin
      int  fr;
      logic e_ex, e_jmp, e_upd;
      exp_t h;
      fr    = DEPTH - sb.size();
      e_ex  = !flush && (fr >= 1);
      e_jmp = !flush && ((fr >= 2) || ((fr == 1) && !ex_valid));
      e_upd = enable && !flush && (sb.size() != 0);
      check_eq("ex_ready", 64'(ex_ready_o), 64'(e_ex));
      check_eq("jmp_ready", 64'(jmp_ready_o), 64'(e_jmp));
      check_eq("bpu_update", 64'(bpu_update_o), 64'(e_upd));
      check_eq("queue_count", 64'(queue_count_o), 64'(sb.size()));
      check_eq("update_cnt", 64'(update_cnt_o), 64'(exp_cnt));
      if (sb.size() != 0) begin
        h = sb[0];
        check_eq("head_pc", 64'(bpu_update_pc_o), 64'(h.pc));
        check_eq("head_taken", 64'(bpu_taken_o), 64'(h.taken));
        check_eq("head_target", 64'(bpu_target_o), 64'(h.target));
        check_eq("head_is_branch", 64'(bpu_is_branch_o), 64'd1);
      end else begin
        check_eq("empty_bus", {bpu_update_pc_o, bpu_target_o} | 64'(bpu_taken_o) | 64'(bpu_is_branch_o), 64'd0);
      end
      if (flush) begin
        sb.delete();
      end else begin
        if (e_upd) begin
          void'(sb.pop_front());
          exp_cnt++;
        end
        if (ex_valid && e_ex) sb.push_back('{ex_pc, ex_taken, ex_target});
        if (jmp_valid && e_jmp) sb.push_back('{jmp_pc, 1'b1, jmp_target});
      end
      if (sb.size() > max_seen) max_seen = sb.size();
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic offer_ex(input logic [AW-1:0] pc, input logic tk, input logic [AW-1:0] tg);
    ex_valid = 1'b1; ex_pc = pc; ex_taken = tk; ex_target = tg;
  endtask

  task automatic idle_inputs();
    ex_valid = 1'b0; jmp_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic do_reset();
    #1 rst_ni = 1'b0;
    idle_inputs();
    #2;
    check_eq("rst_ex_ready", 64'(ex_ready_o), 64'd1);
    check_eq("rst_jmp_ready", 64'(jmp_ready_o), 64'd1);
    check_eq("rst_bus", {bpu_update_pc_o, bpu_target_o} | 64'(bpu_update_o) | 64'(bpu_taken_o) | 64'(bpu_is_branch_o), 64'd0);
    check_eq("rst_count", 64'(queue_count_o), 64'd0);
    check_eq("rst_upd_cnt", 64'(update_cnt_o), 64'd0);
    step();
    rst_ni = 1'b1;
  endtask

  initial begin
    do_reset();

    // 1: single EX update, next-cycle delivery
    enable = 1'b1;
    offer_ex(32'h100, 1'b1, 32'h200);
    step();
    ex_valid = 1'b0;
    @(negedge clk_i);
    check_eq("t1_update", 64'(bpu_update_o), 64'd1);
    check_eq("t1_pc", 64'(bpu_update_pc_o), 64'h100);
    step();
    check_eq("t1_upd_cnt", 64'(update_cnt_o), 64'd1);

    // 2: EX and JMP together, delivered back to back
    offer_ex(32'h10, 1'b0, 32'h14);
    jmp_valid = 1'b1; jmp_pc = 32'h20; jmp_target = 32'h80;
    step();
    idle_inputs();
    @(negedge clk_i);
    check_eq("t2_first", 64'(bpu_update_pc_o), 64'h10);
    step();
    @(negedge clk_i);
    check_eq("t2_second", 64'(bpu_update_pc_o), 64'h20);
    step();

    // 3: fill while held, then drain
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      offer_ex(32'h300 + 32'(i * 4), i[0], 32'h400 + 32'(i));
      step();
    end
    ex_valid = 1'b0;
    @(negedge clk_i);
    check_eq("t3_full", 64'(queue_count_o), 64'd4);
    check_eq("t3_ex_ready", 64'(ex_ready_o), 64'd0);
    step();
    enable = 1'b1;
    repeat (6) step();

    // 4: count=3, both valid -> JMP deferred one cycle
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      offer_ex(32'h500 + 32'(i * 4), 1'b1, 32'h600);
      step();
    end
    enable = 1'b1;
    offer_ex(32'h50C, 1'b0, 32'h510);
    jmp_valid = 1'b1; jmp_pc = 32'h700; jmp_target = 32'h900;
    @(negedge clk_i);
    check_eq("t4_jmp_blocked", 64'(jmp_ready_o), 64'd0);
    step();
    ex_valid = 1'b0;
    @(negedge clk_i);
    check_eq("t4_jmp_accept", 64'(jmp_ready_o), 64'd1);
    step();
    jmp_valid = 1'b0;
    repeat (6) step();

    // 5: flush with a partly full queue
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      offer_ex(32'hA00 + 32'(i * 4), 1'b1, 32'hB00);
      step();
    end
    enable = 1'b1;
    flush = 1'b1;
    offer_ex(32'hC00, 1'b1, 32'hD00);
    @(negedge clk_i);
    check_eq("t5_ex_ready", 64'(ex_ready_o), 64'd0);
    check_eq("t5_update", 64'(bpu_update_o), 64'd0);
    step();
    idle_inputs();
    @(negedge clk_i);
    check_eq("t5_count", 64'(queue_count_o), 64'd0);
    check_eq("t5_no_update", 64'(bpu_update_o), 64'd0);
    repeat (3) step();

    // 6: random interleaved traffic across many pointer wraps
    for (int i = 0; i < 80; i++) begin
      enable    = 1'($urandom_range(0, 2) != 0);
      ex_valid  = 1'($urandom_range(0, 1));
      ex_pc     = $urandom; ex_taken = 1'($urandom_range(0, 1)); ex_target = $urandom;
      jmp_valid = 1'($urandom_range(0, 1));
      jmp_pc    = $urandom; jmp_target = $urandom;
      flush     = 1'($urandom_range(0, 29) == 0);
      step();
    end
    idle_inputs();
    enable = 1'b1;
    repeat (6) step();
    check_eq("t6_max_count", 64'(max_seen <= DEPTH), 64'd1);

    // Mid-operation reset drops queued entries
    enable = 1'b0;
    offer_ex(32'hE00, 1'b1, 32'hF00);
    step();
    step();
    do_reset();
    @(negedge clk_i);
    check_eq("rst_mid_count", 64'(queue_count_o), 64'd0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
